// File: rtl/serial_deserializer_if.sv
// Bit-serial link / word consumer bundle for serial_deserializer.
// Optional overrun_out exists only when DESERIALIZER_OVERRUN_EN is defined.
interface serial_deserializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  data_in;
   logic                  write_in;
   logic                  ack_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_ready;
   logic                  status_out;
   logic                  state_dbg;
`ifdef DESERIALIZER_OVERRUN_EN
   logic                  overrun_out;
`endif

   // Handshake: a bit transfers on an edge where write_in=1 and status_out=1;
   // a word transfers on an edge where data_ready=1 and ack_in=1.
`ifdef DESERIALIZER_OVERRUN_EN
   modport master (
      output data_in, write_in, ack_in,
      input  data_out, data_ready, status_out, state_dbg, overrun_out
   );
   modport slave (
      input  data_in, write_in, ack_in,
      output data_out, data_ready, status_out, state_dbg, overrun_out
   );
`else
   modport master (
      output data_in, write_in, ack_in,
      input  data_out, data_ready, status_out, state_dbg
   );
   modport slave (
      input  data_in, write_in, ack_in,
      output data_out, data_ready, status_out, state_dbg
   );
`endif
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: shifts in DATA_WIDTH bits, holds the word until acked.
// Define DESERIALIZER_OVERRUN_EN to add the sticky overrun_out flag.
module serial_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                   clk_100khz,
   input  logic                   reset,
   serial_deserializer_if.slave   bus
);
   localparam int CW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic {
      S_RECV = 1'b0,
      S_FULL = 1'b1
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [DATA_WIDTH-1:0] shreg_d;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  data_ready_q;
   logic                  status_q;
   logic                  last_bit;
`ifdef DESERIALIZER_OVERRUN_EN
   logic                  overrun_q;
`endif

   always_comb begin
      shreg_d = shreg_q;
      if (MSB_FIRST) begin
         shreg_d = {shreg_q[DATA_WIDTH-2:0], bus.data_in};
      end else begin
         shreg_d = {bus.data_in, shreg_q[DATA_WIDTH-1:1]};
      end
   end

   assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));

   always_ff @(posedge clk_100khz) begin
      if (!reset) begin
         state_q      <= S_RECV;
         shreg_q      <= '0;
         cnt_q        <= '0;
         data_out_q   <= '0;
         data_ready_q <= 1'b0;
         status_q     <= 1'b1;
`ifdef DESERIALIZER_OVERRUN_EN
         overrun_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_RECV: begin
               if (bus.write_in) begin
                  shreg_q <= shreg_d;
                  if (last_bit) begin
                     // Publish the word including the bit arriving on this edge.
                     data_out_q   <= shreg_d;
                     cnt_q        <= '0;
                     state_q      <= S_FULL;
                     data_ready_q <= 1'b1;
                     status_q     <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            S_FULL: begin
`ifdef DESERIALIZER_OVERRUN_EN
               if (bus.write_in) begin
                  overrun_q <= 1'b1;
               end
`endif
               // A bit written alongside the ack is dropped; accepting resumes next cycle.
               if (bus.ack_in) begin
                  state_q      <= S_RECV;
                  data_ready_q <= 1'b0;
                  status_q     <= 1'b1;
               end
            end
            default: begin
               state_q      <= S_RECV;
               data_ready_q <= 1'b0;
               status_q     <= 1'b1;
            end
         endcase
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_ready = data_ready_q;
   assign bus.status_out = status_q;
   assign bus.state_dbg  = state_q;
`ifdef DESERIALIZER_OVERRUN_EN
   assign bus.overrun_out = overrun_q;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (MSB_FIRST=1, DATA_WIDTH=8) with a word scoreboard.
module tb_serial_deserializer;
   localparam int W = 8;

   logic clk_100khz;
   logic reset;
   int   total;
   int   bad;
   logic [W-1:0] exp_q[$];

   serial_deserializer_if #(.DATA_WIDTH(W)) intf ();

   serial_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk_100khz (clk_100khz),
      .reset      (reset),
      .bus        (intf.slave)
   );

   initial clk_100khz = 1'b0;
   always #5 clk_100khz = ~clk_100khz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive at the falling edge, then sample 1 time unit after the next rising edge.
   task automatic step(input logic rst_n, input logic d, input logic w, input logic a);
      @(negedge clk_100khz);
      reset         = rst_n;
      intf.data_in  = d;
      intf.write_in = w;
      intf.ack_in   = a;
      @(posedge clk_100khz);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   task automatic chk_state(input string tag, input logic rdy, input logic st);
      chk({tag, "_ready"}, 32'(intf.data_ready), 32'(rdy));
      chk({tag, "_status"}, 32'(intf.status_out), 32'(st));
   endtask

   // Send a full word MSB first, optionally with random idle gaps between bits.
   task automatic send_word(input string tag, input logic [W-1:0] word, input bit gaps);
      logic [W-1:0] exp_w;
      for (int i = 0; i < W; i++) begin
         if (gaps && i > 0) begin
            idle($urandom_range(1, 3));
            chk({tag, "_gap_ready"}, 32'(intf.data_ready), 32'h0);
         end
         if (i == W - 1) exp_q.push_back(word);
         step(1'b1, word[W-1-i], 1'b1, 1'b0);
         if (i < W - 1) chk({tag, "_partial_ready"}, 32'(intf.data_ready), 32'h0);
      end
      chk_state({tag, "_done"}, 1'b1, 1'b0);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_sb observed=word expected=empty_queue", tag);
      end else begin
         exp_w = exp_q.pop_front();
         chk({tag, "_word"}, 32'(intf.data_out), 32'(exp_w));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset         = 1'b0;
      intf.data_in  = 1'b0;
      intf.write_in = 1'b0;
      intf.ack_in   = 1'b0;

      // Reset state.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_state("reset", 1'b0, 1'b1);
      chk("reset_data", 32'(intf.data_out), 32'h00);
      chk("reset_dbg", 32'(intf.state_dbg), 32'h0);
`ifdef DESERIALIZER_OVERRUN_EN
      chk("reset_overrun", 32'(intf.overrun_out), 32'h0);
`endif
      idle(2);

      // 0x55 back to back.
      send_word("w55", 8'h55, 1'b0);

      // Writes while FULL are ignored.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0);
         chk("full_hold_data", 32'(intf.data_out), 32'h55);
         chk_state("full_hold", 1'b1, 1'b0);
      end
`ifdef DESERIALIZER_OVERRUN_EN
      chk("overrun_set", 32'(intf.overrun_out), 32'h1);
`endif

      // Ack held for two cycles releases once; second cycle lands in RECV harmlessly.
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk_state("ack1", 1'b0, 1'b1);
      chk("ack1_data", 32'(intf.data_out), 32'h55);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk_state("ack2", 1'b0, 1'b1);
      chk("ack2_data", 32'(intf.data_out), 32'h55);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // Partial word discarded by reset.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("partial_data", 32'(intf.data_out), 32'h55);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_state("midreset", 1'b0, 1'b1);
      chk("midreset_data", 32'(intf.data_out), 32'h00);
`ifdef DESERIALIZER_OVERRUN_EN
      chk("midreset_overrun", 32'(intf.overrun_out), 32'h0);
`endif
      send_word("wA3", 8'hA3, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk_state("ackA3", 1'b0, 1'b1);

      // Idle gaps between bits keep the count.
      send_word("wB2", 8'hB2, 1'b1);

      // Same-cycle ack and write in FULL: bit dropped, next word unaffected.
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk_state("ackwr", 1'b0, 1'b1);
      chk("ackwr_data", 32'(intf.data_out), 32'hB2);
      send_word("wC4", 8'hC4, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Random words with random gaps.
      for (int k = 0; k < 4; k++) begin
         send_word("wrand", W'($urandom_range(0, 255)), 1'b1);
         step(1'b1, 1'b0, 1'b0, 1'b1);
         chk_state("rand_ack", 1'b0, 1'b1);
      end

      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
